arbitro_prioridade: RTL and testbench
=====================================

ARBITRO_PRIORIDADE -- requirements
Module: arbitro_prioridade

Interface
REQ-001 SHALL have parameter N_USERS, default 4: number of requesting users, minimum 2.
REQ-002 SHALL have parameter PRIO_W, default 3: priority code width per user.
REQ-003 SHALL have parameter MAX_HOLD, default 8: maximum consecutive grant cycles per tenure.
REQ-004 SHALL have port clk  in  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-006 SHALL have port req  in  N_USERS: per-user request.
REQ-007 SHALL have port user_prio  in  N_USERS*PRIO_W: packed codes; user i at bits [i*PRIO_W +: PRIO_W].
REQ-008 SHALL have port done  in  1: holder releases the grant.
REQ-009 SHALL have port grant  out  N_USERS: one-hot grant, registered.
REQ-010 SHALL have port grant_idx  out  clog2(N_USERS): index of holder; 0 when grant=0.
REQ-011 SHALL have port lowest_prio  out  PRIO_W: minimum code among eligible requesters at the last arbitration.
REQ-012 SHALL have port busy  out  1: high while in GRANT.

Function
REQ-013 SHALL treat user i as eligible when req[i]=1 and its code is nonzero; code 0 never wins and is excluded from lowest_prio.
REQ-014 SHALL implement FSM states IDLE and GRANT only.
REQ-015 In IDLE with at least one eligible user, SHALL register the winner: grant, grant_idx, and lowest_prio update at the next edge; state becomes GRANT.
REQ-016 SHALL select as winner the eligible user with the numerically largest code.
REQ-017 On equal largest codes, SHALL pick the first tied index at or after (last_idx+1) mod N_USERS, wrapping.
REQ-018 SHALL set last_idx to the winner on every grant.
REQ-019 In IDLE with no eligible user, SHALL keep grant=0, busy=0, and lowest_prio unchanged.
REQ-020 In GRANT, SHALL release when done=1, when req[grant_idx]=0, or when the hold counter reaches MAX_HOLD-1; on release, grant=0 and state=IDLE at the next edge.
REQ-021 Hold counter SHALL clear on entry to GRANT, increment each GRANT cycle, and never wrap.
REQ-022 After every release, SHALL spend at least one cycle in IDLE with grant=0; no back-to-back tenure.
REQ-023 In GRANT, SHALL ignore changes to user_prio of non-holders, except as in REQ-028.
REQ-024 Simultaneous done and a timeout in the same cycle SHALL be a single release.

Reset
REQ-025 On rst=1 at a clock edge, SHALL force grant=0, grant_idx=0, lowest_prio=0, busy=0, state=IDLE, hold counter=0, last_idx=N_USERS-1.
REQ-026 Reset asserted during GRANT SHALL abort the tenure with no release cycle; rst has priority over every other input.

Configuration
REQ-027 SHALL compile preemption in only when macro ARB_PREEMPT_EN is defined.
REQ-028 With ARB_PREEMPT_EN defined, an eligible non-holder whose code strictly exceeds the holder's code SHALL force release at the next edge, as in REQ-020; normal arbitration then follows in IDLE.
REQ-029 Without ARB_PREEMPT_EN, SHALL retain the grant regardless of higher-priority requests until a REQ-020 condition occurs.

Structure
REQ-030 SHALL place the state enum (IDLE, GRANT) and the default PRIO_W constant in shared package arbitro_pkg.
REQ-031 SHALL instantiate sub-module comparador_prio in a reduction tree: two (code, index, valid) inputs in, winner and loser out; tie resolution applies the rotated-index rule.

Verification (N_USERS=4, PRIO_W=3, MAX_HOLD=8)
REQ-032 Reset: rst=1 for one edge with arbitrary inputs -> grant=0000, grant_idx=0, lowest_prio=0, busy=0.
REQ-033 Priority: req=0101, u0=3, u2=6 -> next edge grant=0100, grant_idx=2, lowest_prio=3, busy=1.
REQ-034 Tie/rotation: req=1010, u1=u3=5, last_idx=1 -> grant=1000; after done and one IDLE cycle -> grant=0010.
REQ-035 Timeout and zero code: req=0011, u0=2, u1=0, done=0 held -> grant=0001 for exactly 8 cycles, 0000 for 1 cycle, then 0001 again.
REQ-036 Preemption: u0 (code 2) holds; u3 raises req with code 7 -> with ARB_PREEMPT_EN grant=0000 next edge, then 1000; without it grant stays 0001 until done.
REQ-037 Mid-tenure reset: rst=1 during GRANT -> all outputs zero next edge; with the same requests reapplied and u1=u2=4 tied, grant=0010 is issued (last_idx restored to 3).

Source files
------------

// File: rtl/arbitro_pkg.sv
// Shared definitions for the priority arbiter: FSM state encoding, default
// priority-code width and the rotated-rank helper used for tie breaking.
package arbitro_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int PRIO_W_DEF = 3;

    // Distance of idx from start going upward with wrap at n; smaller wins a tie.
    function automatic int unsigned rot_rank(input int unsigned idx,
                                             input int unsigned start,
                                             input int unsigned n);
        return (idx >= start) ? (idx - start) : (idx + n - start);
    endfunction

endpackage

// File: rtl/comparador_prio.sv
// Two-input priority comparator, one node of the arbitration reduction tree.
// Higher code wins; equal codes go to the index closest at/after start_idx
// in round-robin order. The loser side is reported for min-seeking trees.
module comparador_prio
    import arbitro_pkg::*;
#(
    parameter int N_USERS = 4,
    parameter int PRIO_W  = PRIO_W_DEF,
    parameter int IDX_W   = 2
) (
    input  logic [PRIO_W-1:0] code_a,
    input  logic [IDX_W-1:0]  idx_a,
    input  logic              vld_a,
    input  logic [PRIO_W-1:0] code_b,
    input  logic [IDX_W-1:0]  idx_b,
    input  logic              vld_b,
    input  logic [IDX_W-1:0]  start_idx,
    output logic [PRIO_W-1:0] win_code,
    output logic [IDX_W-1:0]  win_idx,
    output logic              win_vld,
    output logic [PRIO_W-1:0] lose_code,
    output logic [IDX_W-1:0]  lose_idx,
    output logic              lose_vld
);

    logic a_wins;
    int unsigned rank_a;
    int unsigned rank_b;

    // Decide which operand wins and steer both sides accordingly.
    always_comb begin
        rank_a = rot_rank(32'(idx_a), 32'(start_idx), N_USERS);
        rank_b = rot_rank(32'(idx_b), 32'(start_idx), N_USERS);
        a_wins = vld_a && (!vld_b || (code_a > code_b) ||
                           ((code_a == code_b) && (rank_a < rank_b)));
        win_code  = a_wins ? code_a : code_b;
        win_idx   = a_wins ? idx_a  : idx_b;
        win_vld   = vld_a | vld_b;
        lose_code = a_wins ? code_b : code_a;
        lose_idx  = a_wins ? idx_b  : idx_a;
        lose_vld  = vld_a & vld_b;
    end

endmodule

// File: rtl/arbitro_prioridade.sv
// Priority arbiter with round-robin tie breaking and bounded tenure.
// Optional macro ARB_PREEMPT_EN: a strictly higher-priority eligible
// requester forces the current holder to release.
module arbitro_prioridade
    import arbitro_pkg::*;
#(
    parameter int N_USERS  = 4,
    parameter int PRIO_W   = PRIO_W_DEF,
    parameter int MAX_HOLD = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_USERS-1:0]          req,
    input  logic [N_USERS*PRIO_W-1:0]   user_prio,
    input  logic                        done,
    output logic [N_USERS-1:0]          grant,
    output logic [$clog2(N_USERS)-1:0]  grant_idx,
    output logic [PRIO_W-1:0]           lowest_prio,
    output logic                        busy
);

    localparam int IDX_W  = $clog2(N_USERS);
    localparam int P      = 1 << IDX_W;
    localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_USERS - 1);

    arb_state_t        state;
    logic [IDX_W-1:0]  last_idx;
    logic [IDX_W-1:0]  start_idx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [N_USERS-1:0] elig;
    logic              preempt;
    logic              release_now;

    // Max tree (winner selection), heap-indexed: node k has children 2k, 2k+1.
    logic [PRIO_W-1:0] mx_code [1:2*P-1];
    logic [IDX_W-1:0]  mx_idx  [1:2*P-1];
    logic              mx_vld  [1:2*P-1];
    logic [PRIO_W-1:0] mx_lose_code_unused [1:P-1];
    logic [IDX_W-1:0]  mx_lose_idx_unused  [1:P-1];
    logic              mx_lose_vld_unused  [1:P-1];

    // Min tree (lowest eligible code).
    logic [PRIO_W-1:0] mn_code [1:2*P-1];
    logic [IDX_W-1:0]  mn_idx  [1:2*P-1];
    logic              mn_vld  [1:2*P-1];
    logic [PRIO_W-1:0] mnw_code [1:P-1];
    logic [IDX_W-1:0]  mnw_idx  [1:P-1];
    logic              mnw_vld  [1:P-1];
    logic [PRIO_W-1:0] mnl_code [1:P-1];
    logic [IDX_W-1:0]  mnl_idx  [1:P-1];
    logic              mnl_vld  [1:P-1];

    // The index and validity at the min-tree root carry no information we need.
    logic unused_mn_root;
    assign unused_mn_root = ^{mn_idx[1], mn_vld[1]};

    // Round-robin search begins just after the previous winner.
    assign start_idx = (last_idx == IDX_LAST) ? '0 : last_idx + 1'b1;

    genvar g;
    generate
        for (g = 0; g < P; g++) begin : g_leaf
            if (g < N_USERS) begin : g_real
                assign elig[g]       = req[g] && (user_prio[g*PRIO_W +: PRIO_W] != '0);
                assign mx_code[P+g]  = user_prio[g*PRIO_W +: PRIO_W];
                assign mx_vld[P+g]   = elig[g];
            end else begin : g_pad
                assign mx_code[P+g]  = '0;
                assign mx_vld[P+g]   = 1'b0;
            end
            assign mx_idx[P+g]  = IDX_W'(g);
            assign mn_code[P+g] = mx_code[P+g];
            assign mn_idx[P+g]  = mx_idx[P+g];
            assign mn_vld[P+g]  = mx_vld[P+g];
        end

        for (g = 1; g < P; g++) begin : g_node
            comparador_prio #(
                .N_USERS (N_USERS),
                .PRIO_W  (PRIO_W),
                .IDX_W   (IDX_W)
            ) u_max (
                .code_a    (mx_code[2*g]),
                .idx_a     (mx_idx[2*g]),
                .vld_a     (mx_vld[2*g]),
                .code_b    (mx_code[2*g+1]),
                .idx_b     (mx_idx[2*g+1]),
                .vld_b     (mx_vld[2*g+1]),
                .start_idx (start_idx),
                .win_code  (mx_code[g]),
                .win_idx   (mx_idx[g]),
                .win_vld   (mx_vld[g]),
                .lose_code (mx_lose_code_unused[g]),
                .lose_idx  (mx_lose_idx_unused[g]),
                .lose_vld  (mx_lose_vld_unused[g])
            );

            comparador_prio #(
                .N_USERS (N_USERS),
                .PRIO_W  (PRIO_W),
                .IDX_W   (IDX_W)
            ) u_min (
                .code_a    (mn_code[2*g]),
                .idx_a     (mn_idx[2*g]),
                .vld_a     (mn_vld[2*g]),
                .code_b    (mn_code[2*g+1]),
                .idx_b     (mn_idx[2*g+1]),
                .vld_b     (mn_vld[2*g+1]),
                .start_idx (start_idx),
                .win_code  (mnw_code[g]),
                .win_idx   (mnw_idx[g]),
                .win_vld   (mnw_vld[g]),
                .lose_code (mnl_code[g]),
                .lose_idx  (mnl_idx[g]),
                .lose_vld  (mnl_vld[g])
            );

            // Loser is the smaller code when both sides are valid; otherwise the lone valid one.
            assign mn_code[g] = mnl_vld[g] ? mnl_code[g] : mnw_code[g];
            assign mn_idx[g]  = mnl_vld[g] ? mnl_idx[g]  : mnw_idx[g];
            assign mn_vld[g]  = mnw_vld[g];
        end
    endgenerate

`ifdef ARB_PREEMPT_EN
    logic [PRIO_W-1:0] holder_code;
    assign holder_code = user_prio[grant_idx*PRIO_W +: PRIO_W];
    // Any eligible code above the holder's can only belong to a non-holder.
    assign preempt = mx_vld[1] && (mx_code[1] > holder_code);
`else
    assign preempt = 1'b0;
`endif

    assign release_now = done || !req[grant_idx] || (hold_cnt == HOLD_LAST) || preempt;

    // Arbitration FSM with registered grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            lowest_prio <= '0;
            busy        <= 1'b0;
            hold_cnt    <= '0;
            last_idx    <= IDX_LAST;
        end else begin
            case (state)
                IDLE: begin
                    if (mx_vld[1]) begin
                        grant       <= N_USERS'(1) << mx_idx[1];
                        grant_idx   <= mx_idx[1];
                        lowest_prio <= mn_code[1];
                        last_idx    <= mx_idx[1];
                        hold_cnt    <= '0;
                        busy        <= 1'b1;
                        state       <= GRANT;
                    end else begin
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        grant     <= '0;
                        grant_idx <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_prioridade.sv
// Bench for arbitro_prioridade (N_USERS=4, PRIO_W=3, MAX_HOLD=8); honours
// ARB_PREEMPT_EN in both the DUT and the reference model.
module tb_arbitro_prioridade;

    localparam int N  = 4;
    localparam int PW = 3;
    localparam int MH = 8;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*PW-1:0] user_prio;
    logic            done;
    logic [N-1:0]    grant;
    logic [1:0]      grant_idx;
    logic [PW-1:0]   lowest_prio;
    logic            busy;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit m_busy;
    int m_holder;
    int m_last;
    int m_hold;
    int m_low;

    arbitro_prioridade #(.N_USERS(N), .PRIO_W(PW), .MAX_HOLD(MH)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .user_prio   (user_prio),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .lowest_prio (lowest_prio),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int code_of(input int i);
        return int'(user_prio[i*PW +: PW]);
    endfunction

    function automatic bit elig(input int i);
        return req[i] && (code_of(i) != 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs presently applied.
    task automatic model_step();
        int best, maxc, minc;
        bit rel;
        if (rst) begin
            m_busy = 0; m_holder = 0; m_low = 0; m_last = N - 1; m_hold = 0;
        end else if (!m_busy) begin
            best = -1; maxc = 0; minc = 1 << PW;
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_last + 1 + k) % N;
                if (elig(i) && code_of(i) > maxc) begin
                    best = i; maxc = code_of(i);
                end
                if (elig(i) && code_of(i) < minc) minc = code_of(i);
            end
            if (best >= 0) begin
                m_busy = 1; m_holder = best; m_last = best; m_low = minc; m_hold = 0;
            end
        end else begin
            rel = done || !req[m_holder] || (m_hold == MH - 1);
`ifdef ARB_PREEMPT_EN
            for (int j = 0; j < N; j++)
                if (elig(j) && code_of(j) > code_of(m_holder)) rel = 1;
`endif
            if (rel) begin
                m_busy = 0; m_holder = 0;
            end else if (m_hold < MH - 1) begin
                m_hold++;
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0] exp_grant;
        model_step();
        @(posedge clk);
        #1;
        exp_grant = m_busy ? (N'(1) << m_holder) : '0;
        check("grant", 32'(grant), 32'(exp_grant));
        check("grant_idx", 32'(grant_idx), 32'(m_holder));
        check("lowest_prio", 32'(lowest_prio), 32'(m_low));
        check("busy", 32'(busy), 32'(m_busy));
    endtask

    function automatic logic [N*PW-1:0] prios(input int u3, input int u2, input int u1, input int u0);
        return {PW'(u3), PW'(u2), PW'(u1), PW'(u0)};
    endfunction

    initial begin
        rst = 1'b1; req = 4'b1111; user_prio = 12'($urandom); done = 1'b0;

        // Reset with arbitrary inputs
        tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_idx", 32'(grant_idx), 32'h0);
        check("rst_low", 32'(lowest_prio), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0; req = '0;
        tick();

        // Highest code wins, lowest eligible code reported
        req = 4'b0101; user_prio = prios(0, 6, 0, 3);
        tick();
        check("prio_grant", 32'(grant), 32'b0100);
        check("prio_idx", 32'(grant_idx), 32'd2);
        check("prio_low", 32'(lowest_prio), 32'd3);
        check("prio_busy", 32'(busy), 32'd1);
        req = '0;
        tick();
        tick();

        // Tie rotation: first make u1 the last winner
        req = 4'b0010; user_prio = prios(0, 0, 5, 0);
        tick();
        check("rot_setup", 32'(grant), 32'b0010);
        done = 1'b1; req = '0;
        tick();
        done = 1'b0;
        req = 4'b1010; user_prio = prios(5, 0, 5, 0);
        tick();
        check("tie_first", 32'(grant), 32'b1000);
        done = 1'b1;
        tick();
        check("tie_release", 32'(grant), 32'b0000);
        done = 1'b0;
        tick();
        check("tie_second", 32'(grant), 32'b0010);
        req = '0;
        tick();
        tick();

        // Timeout with a zero-coded requester
        req = 4'b0011; user_prio = prios(0, 0, 0, 2);
        for (int c = 0; c < MH; c++) begin
            tick();
            check("hold_grant", 32'(grant), 32'b0001);
        end
        check("hold_low", 32'(lowest_prio), 32'd2);
        tick();
        check("hold_gap", 32'(grant), 32'b0000);
        tick();
        check("hold_regrant", 32'(grant), 32'b0001);
        req = '0;
        tick();
        tick();

        // Higher-priority arrival while u0 holds
        req = 4'b0001; user_prio = prios(0, 0, 0, 2);
        tick();
        check("pre_hold", 32'(grant), 32'b0001);
        req = 4'b1001; user_prio = prios(7, 0, 0, 2);
        tick();
`ifdef ARB_PREEMPT_EN
        check("pre_release", 32'(grant), 32'b0000);
        tick();
        check("pre_new", 32'(grant), 32'b1000);
`else
        check("pre_keep", 32'(grant), 32'b0001);
        tick();
        check("pre_keep2", 32'(grant), 32'b0001);
        done = 1'b1;
        tick();
        check("pre_done", 32'(grant), 32'b0000);
        done = 1'b0;
        tick();
        check("pre_new", 32'(grant), 32'b1000);
`endif
        req = '0;
        tick();
        tick();

        // Mid-tenure reset restores rotation start
        req = 4'b0010; user_prio = prios(0, 0, 4, 0);
        tick();
        check("mrst_hold", 32'(grant), 32'b0010);
        rst = 1'b1;
        tick();
        check("mrst_grant", 32'(grant), 32'h0);
        check("mrst_busy", 32'(busy), 32'h0);
        rst = 1'b0; req = 4'b0110; user_prio = prios(0, 4, 4, 0);
        tick();
        check("mrst_tie", 32'(grant), 32'b0010);
        req = '0;
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) begin
                req       = N'($urandom);
                user_prio = 12'($urandom);
            end
            done = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
